// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data-memory responder for the 32-bit RISC-V pipeline.
// It models a word-organised SRAM with WAIT_CYCLES wait states, returns aligned
// and extended load data, and stalls the pipeline while a transaction is in flight.
//
// Ports:
//   CLK        - clock, rising edge
//   rst        - asynchronous active-high reset
//   req_valid  - request present
//   req_we     - 1 = store, 0 = load
//   req_funct3 - 000 b/sb, 001 h/sh, 010 w/sw, 100 lbu, 101 lhu
//   req_addr   - byte address
//   req_wdata  - store data, right-justified
//   req_ready  - responder can accept a request (registered)
//   rsp_valid  - one-cycle response strobe (registered)
//   rsp_rdata  - extended load data; 0 for stores and faults (registered)
//   rsp_err    - access fault, qualified by rsp_valid (registered)
//   stall      - hold F/D/E/M pipeline registers (combinational)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [2:0]  cap_funct3;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  // Access fields: with zero wait states the array access happens on the
  // accept edge itself, so the live request is used instead of the capture.
  logic        acc_we;
  logic [2:0]  acc_funct3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        enter_resp;
  logic        acc_err;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] rword;
  logic [31:0] ldata;

  always_comb begin
    if (state == IDLE) begin
      acc_we     = req_we;
      acc_funct3 = req_funct3;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = cap_we;
      acc_funct3 = cap_funct3;
      acc_addr   = cap_addr;
      acc_wdata  = cap_wdata;
    end
  end

  assign enter_resp = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == '0));

  assign stall = ((state == IDLE) && req_valid) || (state == WAIT);

  always_comb begin
    acc_err = 1'b0;
    if ((acc_funct3[1:0] == 2'b01) && acc_addr[0])
      acc_err = 1'b1;
    if ((acc_funct3 == 3'b010) && (acc_addr[1:0] != 2'b00))
      acc_err = 1'b1;
    if (!acc_we && ((acc_funct3 == 3'b011) || (acc_funct3 == 3'b110) || (acc_funct3 == 3'b111)))
      acc_err = 1'b1;
    if (acc_we && (acc_funct3[2] || (acc_funct3[1:0] == 2'b11)))
      acc_err = 1'b1;
    if (acc_addr[31:2] >= DEPTH30)
      acc_err = 1'b1;
  end

  assign idx   = acc_addr[AW+1:2];
  assign rword = mem[idx];

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be    = '0;
    wword = '0;
    case (acc_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << acc_addr[1:0];
        wword = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{acc_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = acc_wdata;
      end
    endcase
  end

  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = rword[8*acc_addr[1:0] +: 8];
    lane_h = acc_addr[1] ? rword[31:16] : rword[15:0];
    ldata  = '0;
    case (acc_funct3)
      3'b000:  ldata = {{24{lane_b[7]}}, lane_b};
      3'b001:  ldata = {{16{lane_h[15]}}, lane_h};
      3'b010:  ldata = rword;
      3'b100:  ldata = {24'h0, lane_b};
      3'b101:  ldata = {16'h0, lane_h};
      default: ldata = '0;
    endcase
    if (acc_we || acc_err)
      ldata = '0;
  end

  always_ff @(posedge CLK) begin
    if (!rst && enter_resp && acc_we && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i])
          mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_funct3 <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we     <= req_we;
            cap_funct3 <= req_funct3;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= ldata;
              rsp_err   <= acc_err;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ldata;
            rsp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized traffic
// checked against a byte-level reference model of the memory.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WC    = 2;

  logic        CLK = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;

  logic        v0, we0;
  logic [2:0]  f0;
  logic [31:0] a0, d0;
  logic        ready0, rv0, err0, stall0;
  logic [31:0] rd0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [16];

  always #5 CLK = ~CLK;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .stall(stall)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .rst(rst), .req_valid(v0), .req_we(we0),
    .req_funct3(f0), .req_addr(a0), .req_wdata(d0),
    .req_ready(ready0), .rsp_valid(rv0), .rsp_rdata(rd0),
    .rsp_err(err0), .stall(stall0)
  );

  // ---------------- reference model ----------------
  function automatic logic exp_fault(input logic we, input int unsigned f, input logic [31:0] a);
    if ((a / 4) >= DEPTH) return 1'b1;
    if (we && f > 2) return 1'b1;
    if (!we && (f == 3 || f == 6 || f == 7)) return 1'b1;
    if ((f % 4) == 1 && (a % 2) != 0) return 1'b1;
    if ((f % 4) == 2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input int unsigned f, input logic [31:0] a);
    logic [31:0] b, h;
    int unsigned sh;
    sh = 8 * (a % 4);
    b = (w >> sh) & 32'hFF;
    h = (w >> sh) & 32'hFFFF;
    case (f)
      0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4: return b;
      5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] apply_store(input logic [31:0] w, input int unsigned f,
                                              input logic [31:0] a, input logic [31:0] d);
    logic [31:0] m, val;
    int unsigned sh;
    sh = 8 * (a % 4);
    case (f)
      0: begin m = 32'hFF << sh;   val = (d & 32'hFF) << sh; end
      1: begin m = 32'hFFFF << sh; val = (d & 32'hFFFF) << sh; end
      default: begin m = 32'hFFFFFFFF; val = d; end
    endcase
    return (w & ~m) | (val & m);
  endfunction

  // ---------------- driver ----------------
  // Called just after a negedge with the DUT idle; returns at a negedge idle again.
  task automatic do_txn(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat, output logic flow_ok);
    req_valid = 1'b1; req_we = we; req_funct3 = f; req_addr = a; req_wdata = d;
    #1;
    flow_ok = (req_ready === 1'b1) && (stall === 1'b1);
    @(posedge CLK);
    lat = 0; rd = 'x; er = 1'bx;
    while (lat < 40) begin
      @(negedge CLK);
      lat++;
      if (rsp_valid === 1'b1) begin
        rd = rsp_rdata; er = rsp_err;
        if (stall !== 1'b0 || req_ready !== 1'b0) flow_ok = 1'b0;
        break;
      end else if (stall !== 1'b1 || req_ready !== 1'b0) begin
        flow_ok = 1'b0;
      end
    end
    req_valid = 1'b0;
    @(negedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    v0 = 1'b0; we0 = 1'b0; f0 = '0; a0 = '0; d0 = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, stall} !== 4'b1000 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset: ready/valid/err/stall=%b rdata=%h, expected 1000 rdata=0",
               {req_ready, rsp_valid, rsp_err, stall}, rsp_rdata);
    end
    rst = 1'b0;
    @(negedge CLK);
  endtask

  task automatic run_one(input string name, input logic we, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd; logic er; int lat; logic ok;
    do_txn(we, f, a, d, rd, er, lat, ok);
    checks++;
    if (rd !== exp_rd || er !== exp_er || lat != WC + 1 || ok !== 1'b1) begin
      errors++;
      $display("FAIL %s: rdata=%h err=%b lat=%0d flow=%b, expected rdata=%h err=%b lat=%0d flow=1",
               name, rd, er, lat, ok, exp_rd, exp_er, WC + 1);
    end
  endtask

  task automatic test_store_load();
    run_one("sw_0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    run_one("lw_0x10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_byte();
    run_one("sw_init", 1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0);
    run_one("sb_0x13", 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0);
    run_one("lw_after_sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5223344, 1'b0);
    run_one("lb_0x13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0);
    run_one("lbu_0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 1'b0);
  endtask

  task automatic test_half();
    run_one("sw_zero", 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0);
    run_one("sh_0x12", 1'b1, 3'b001, 32'h12, 32'h00008001, 32'h0, 1'b0);
    run_one("lh_0x12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0);
    run_one("lhu_0x12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0);
    run_one("lw_after_sh", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80010000, 1'b0);
  endtask

  task automatic test_faults();
    run_one("lw_mis", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
    run_one("sh_mis", 1'b1, 3'b001, 32'h01, 32'hFFFF, 32'h0, 1'b1);
    run_one("lw_range", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
    run_one("ld_f011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    run_one("st_f100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    run_one("sw_range", 1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1);
    run_one("lw_unchanged", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80010000, 1'b0);
  endtask

  task automatic test_reset_abort();
    logic seen;
    run_one("sw_0x20_zero", 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (stall !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait: stall=%b ready=%b valid=%b, expected 1 0 0", stall, req_ready, rsp_valid);
    end
    rst = 1'b1; req_valid = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, stall} !== 4'b1000 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_reset: ready/valid/err/stall=%b rdata=%h, expected 1000 rdata=0",
               {req_ready, rsp_valid, rsp_err, stall}, rsp_rdata);
    end
    @(negedge CLK);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_rsp: rsp_valid seen=%b, expected 0", seen);
    end
    run_one("lw_after_abort", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp_rd; logic er, we, exp_er, ok; int lat;
    int unsigned f;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_txn(1'b1, 3'b010, 32'(i * 4), d, rd, er, lat, ok);
      model[i] = d;
    end
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f  = $urandom_range(0, 7);
      a  = ($urandom_range(0, 7) == 0) ? 32'(DEPTH * 4) + 32'($urandom_range(0, 4095))
                                       : 32'($urandom_range(0, 63));
      d  = $urandom;
      exp_er = exp_fault(we, f, a);
      exp_rd = (exp_er || we) ? 32'h0 : exp_load(model[(a / 4) % 16], f, a);
      do_txn(we, 3'(f), a, d, rd, er, lat, ok);
      if (we && !exp_er) model[a / 4] = apply_store(model[a / 4], f, a, d);
      checks++;
      if (rd !== exp_rd || er !== exp_er || lat != WC + 1 || ok !== 1'b1) begin
        errors++;
        $display("FAIL random_%0d we=%b f=%0d a=%h: rdata=%h err=%b lat=%0d flow=%b, expected rdata=%h err=%b lat=%0d",
                 n, we, f, a, rd, er, lat, ok, exp_rd, exp_er, WC + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  exp_hs;
    logic [31:0] exp_rd;
    v0 = 1'b1; we0 = 1'b1; f0 = 3'b010; a0 = 32'h4; d0 = 32'hCAFE0123;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        we0 = 1'b0;
        #1;
      end
      exp_hs = (i % 2 == 0) ? 3'b101 : 3'b010;
      exp_rd = (i % 2 == 1 && i > 6) ? 32'hCAFE0123 : 32'h0;
      checks++;
      if ({ready0, rv0, stall0} !== exp_hs || rd0 !== exp_rd || err0 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_%0d: ready/valid/stall=%b rdata=%h err=%b, expected %b rdata=%h err=0",
                 i, {ready0, rv0, stall0}, rd0, err0, exp_hs, exp_rd);
      end
      @(negedge CLK);
    end
    v0 = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte();
    test_half();
    test_faults();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the M stage of the 32-bit RISC-V pipeline. It accepts one load or store request per transaction from the datapath: address, store data, funct3 and a write flag. It models a word-organised SRAM with a configurable number of wait states. It returns aligned, sign- or zero-extended load data to the W-stage register, and stalls the pipeline while a transaction is in flight.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; legal word index is 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 2: wait states between accept and response; legal range 0..15.

- CLK  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size/type: 000 b/sb, 001 h/sh, 010 w/sw, 100 lbu, 101 lhu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_ready  out  1  responder can accept a request.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access fault, qualified by rsp_valid.
- stall  out  1  hold the F/D/E/M pipeline registers.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture we, funct3, addr and wdata.
  - Go to WAIT with counter = WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES = 0.
- WAIT:
  - req_ready = 0; the counter decrements each cycle.
  - At counter = 0, go to RESP.
  - The array access (write commit or read sample) happens on the edge that enters RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with rsp_rdata and rsp_err registered.
  - Always returns to IDLE; inputs are ignored in this state.
- stall = (IDLE & req_valid) | WAIT. It is 0 in RESP, which lets the pipeline advance with the response.
- Fault (rsp_err = 1) is any one of:
  - misaligned half access: funct3[1:0] = 01 with addr[0] = 1;
  - misaligned word access: funct3 = 010 with addr[1:0] != 0;
  - illegal funct3 for a load: 011, 110 or 111;
  - illegal funct3 for a store: anything other than 000, 001 or 010;
  - out-of-range word index: addr[31:2] >= DEPTH_WORDS.
- On a fault: no array write, rsp_rdata = 0.
- Stores, byte-lane enables:
  - sw writes all 4 lanes.
  - sh writes lanes {1,0} when addr[1] = 0, otherwise lanes {3,2}.
  - sb writes lane addr[1:0].
  - Store data is replicated across lanes: wdata[15:0] twice for sh, wdata[7:0] four times for sb.
  - Lanes that are not enabled are unchanged.
- Loads: select the lane(s) by addr[1:0], then extend.
  - lb and lh sign-extend from bit 7 and bit 15 respectively.
  - lbu and lhu zero-extend.
  - lw returns the word unchanged.
- Array contents are not reset; a read before any write returns X in simulation.

## Timing
- Reset values:
  - state = IDLE, counter = 0;
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
  - stall = 0, given req_valid = 0 (stall follows req_valid combinationally in IDLE).
- Latency: a request accepted at edge k produces rsp_valid high during cycle k+WAIT_CYCLES+1.
  - Example: WAIT_CYCLES = 2 gives the response 3 cycles after accept.
  - Throughput is one transaction per WAIT_CYCLES+2 cycles.
- Requests are ignored when req_ready = 0. The requester holds its fields stable until rsp_valid; only the captured copy is used.
- Reset asserted in WAIT aborts the transaction with no array write; reset in RESP drops the response.
- A store followed by a load to the same word returns the new data, because the write commits before the next accept.
- req_ready, rsp_valid, rsp_rdata and rsp_err are registered. stall is combinational from req_valid and state.

## Test plan
- sw addr 0x10, data 0xDEADBEEF, then lw 0x10, WAIT_CYCLES = 2 -> each rsp_valid arrives 3 cycles after accept; lw returns 0xDEADBEEF, rsp_err = 0.
- sb 0x13 data 0x000000A5 over word 0x11223344, then lw 0x10 -> 0xA5223344; lb 0x13 -> 0xFFFFFFA5; lbu 0x13 -> 0x000000A5.
- sh 0x12 data 0x8001 over word 0, then lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001; lw 0x10 -> 0x80010000.
- Faults: lw 0x11, sh 0x01, lw 0x1000 (DEPTH_WORDS = 1024), load with funct3 = 011 -> rsp_err = 1 and rsp_rdata = 0 for each; a following lw shows the word unchanged.
- Pulse rst during WAIT of sw 0x20 data 0x12345678 (word previously 0) -> outputs return to reset values at once, no rsp_valid is produced, and a later lw 0x20 returns 0.
- WAIT_CYCLES = 0 with back-to-back req_valid -> req_ready and rsp_valid alternate; stall is high exactly in accept cycles and low in RESP cycles.
